// File: rtl/rv_plic_core_pkg.sv
// Shared types and width helpers for the parametrised PLIC core.
// Contents:
//   gw_state_e   - per-source gateway state (IDLE / PEND / INSVC), 2 bits
//   calc_src_w   - width of a source ID for a given source count
//   calc_prio_w  - width of a priority value for a given maximum priority
package rv_plic_core_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        INSVC = 2'd2
    } gw_state_e;

    localparam int GwStateW = 2;

    // Never narrower than one bit, so degenerate counts still elaborate.
    function automatic int calc_src_w(input int num_src);
        return (num_src > 1) ? $clog2(num_src) : 1;
    endfunction

    function automatic int calc_prio_w(input int max_prio);
        return (max_prio > 0) ? $clog2(max_prio + 1) : 1;
    endfunction

endpackage

// File: rtl/rv_plic_src_gateway.sv
// Per-source interrupt gateway: IDLE/PEND/INSVC state machine plus a
// one-deep edge latch for edge-mode sources.
// Ports:
//   i_clk, i_rst  - clock, asynchronous active-high reset
//   i_trig        - trigger (synchronised level, or registered rise in edge mode)
//   i_rise        - registered rising edge of the synchronised source
//   i_le          - mode: 0 level, 1 edge
//   i_claim       - granted claim of this source this cycle
//   i_complete    - complete of this source this cycle (any target)
//   o_ip          - pending (state == PEND), registered
module rv_plic_src_gateway
    import rv_plic_core_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_trig,
    input  logic i_rise,
    input  logic i_le,
    input  logic i_claim,
    input  logic i_complete,
    output logic o_ip
);

    gw_state_e r_state;
    logic      r_edge_lat;
    logic      r_ip;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_edge_lat <= 1'b0;
            r_ip       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_trig) begin
                        r_state <= PEND;
                        r_ip    <= 1'b1;
                    end
                end
                PEND: begin
                    if (i_le && i_rise) r_edge_lat <= 1'b1;
                    if (i_claim) begin
                        r_state <= INSVC;
                        r_ip    <= 1'b0;
                    end
                end
                INSVC: begin
                    if (i_complete) begin
                        if (i_le && r_edge_lat) begin
                            // Deliver the held edge; a rise in this very cycle
                            // becomes the next held edge.
                            r_state    <= PEND;
                            r_ip       <= 1'b1;
                            r_edge_lat <= i_rise;
                        end else begin
                            r_state    <= IDLE;
                            r_ip       <= 1'b0;
                            r_edge_lat <= 1'b0;
                        end
                    end else if (i_le && i_rise) begin
                        r_edge_lat <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_ip       <= 1'b0;
                    r_edge_lat <= 1'b0;
                end
            endcase
            // Level mode never holds an edge; last assignment wins.
            if (!i_le) r_edge_lat <= 1'b0;
        end
    end

    assign o_ip = r_ip;

endmodule

// File: rtl/rv_plic_core_param.sv
// Parametrised PLIC core: source synchroniser, edge detection, per-source
// gateways, claim/complete routing and per-target priority arbitration.
// Ports:
//   clk_i, rst_i   - clock, asynchronous active-high reset
//   src_i          - raw interrupt sources (bit 0 ignored)
//   le_i           - per-source mode (0 level, 1 edge)
//   prio_i         - per-source priority, PrioW bits each
//   ie_i           - per-target enable masks, NumSrc bits each
//   threshold_i    - per-target threshold, PrioW bits each
//   claim_i        - per-target claim strobe
//   claim_id_o     - per-target granted ID this cycle (combinational)
//   complete_i     - per-target complete strobe
//   complete_id_i  - per-target ID being completed
//   ip_o           - pending bits
//   irq_o          - per-target interrupt request (registered)
//   irq_id_o       - per-target best pending ID (registered)
module rv_plic_core_param
    import rv_plic_core_pkg::*;
#(
    parameter int NumSrc     = 32,
    parameter int NumTarget  = 2,
    parameter int MaxPrio    = 7,
    parameter int SyncStages = 2,
    localparam int SrcW      = calc_src_w(NumSrc),
    localparam int PrioW     = calc_prio_w(MaxPrio)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NumSrc-1:0]           src_i,
    input  logic [NumSrc-1:0]           le_i,
    input  logic [NumSrc*PrioW-1:0]     prio_i,
    input  logic [NumTarget*NumSrc-1:0] ie_i,
    input  logic [NumTarget*PrioW-1:0]  threshold_i,
    input  logic [NumTarget-1:0]        claim_i,
    output logic [NumTarget*SrcW-1:0]   claim_id_o,
    input  logic [NumTarget-1:0]        complete_i,
    input  logic [NumTarget*SrcW-1:0]   complete_id_i,
    output logic [NumSrc-1:0]           ip_o,
    output logic [NumTarget-1:0]        irq_o,
    output logic [NumTarget*SrcW-1:0]   irq_id_o
);

    logic [NumSrc-1:0]          w_s;
    logic [NumSrc-1:0]          r_s_q;
    logic [NumSrc-1:0]          r_rise;
    logic [NumSrc-1:0]          w_trig;
    logic [NumSrc-1:0]          w_ip;
    logic [NumSrc-1:0]          w_claim_src;
    logic [NumSrc-1:0]          w_complete_src;
    logic [NumTarget-1:0]       w_grant;
    logic [NumTarget*SrcW-1:0]  w_best_id;
    logic [NumTarget*PrioW-1:0] w_best_prio;
    logic [NumTarget-1:0]       w_best_vld;
    logic [NumTarget*SrcW-1:0]  r_irq_id;
    logic [NumTarget-1:0]       r_irq;
    logic                       w_unused;

    generate
        if (SyncStages == 0) begin : g_nosync
            assign w_s = src_i;
        end else begin : g_sync
            logic [NumSrc-1:0] r_sync [SyncStages];
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int i = 0; i < SyncStages; i++) r_sync[i] <= '0;
                end else begin
                    r_sync[0] <= src_i;
                    for (int i = 1; i < SyncStages; i++) r_sync[i] <= r_sync[i-1];
                end
            end
            assign w_s = r_sync[SyncStages-1];
        end
    endgenerate

    // The rise is registered, which costs edge sources one extra cycle but
    // guarantees no rise in the first cycle after reset release.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s_q  <= '0;
            r_rise <= '0;
        end else begin
            r_s_q  <= w_s;
            r_rise <= w_s & ~r_s_q;
        end
    end

    assign w_trig = (le_i & r_rise) | (~le_i & w_s);

    // A claim is granted only while its ID is still pending (irq_id_o lags a
    // claim by a cycle); the lowest-index target wins a shared ID.
    always_comb begin
        w_grant     = '0;
        claim_id_o  = '0;
        w_claim_src = '0;
        for (int t = 0; t < NumTarget; t++) begin
            if (claim_i[t] && (r_irq_id[t*SrcW +: SrcW] != '0) &&
                w_ip[r_irq_id[t*SrcW +: SrcW]]) begin
                w_grant[t] = 1'b1;
                for (int u = 0; u < NumTarget; u++) begin
                    if ((u < t) && w_grant[u] &&
                        (r_irq_id[u*SrcW +: SrcW] == r_irq_id[t*SrcW +: SrcW]))
                        w_grant[t] = 1'b0;
                end
            end
            if (w_grant[t]) begin
                claim_id_o[t*SrcW +: SrcW]           = r_irq_id[t*SrcW +: SrcW];
                w_claim_src[r_irq_id[t*SrcW +: SrcW]] = 1'b1;
            end
        end
    end

    // IDs 0 and >= NumSrc match no gateway; duplicates across targets OR together.
    always_comb begin
        w_complete_src = '0;
        for (int t = 0; t < NumTarget; t++) begin
            for (int k = 1; k < NumSrc; k++) begin
                if (complete_i[t] && (complete_id_i[t*SrcW +: SrcW] == SrcW'(k)))
                    w_complete_src[k] = 1'b1;
            end
        end
    end

    assign w_ip[0] = 1'b0;

    generate
        for (genvar k = 1; k < NumSrc; k++) begin : g_gw
            rv_plic_src_gateway u_gw (
                .i_clk      (clk_i),
                .i_rst      (rst_i),
                .i_trig     (w_trig[k]),
                .i_rise     (r_rise[k]),
                .i_le       (le_i[k]),
                .i_claim    (w_claim_src[k]),
                .i_complete (w_complete_src[k]),
                .o_ip       (w_ip[k])
            );
        end
    endgenerate

    assign ip_o = w_ip;

    // Linear search; strict '>' keeps the lowest ID on ties and, with the
    // threshold compare, excludes priority 0. ip_o[0] is 0, so k=0 never wins.
    always_comb begin
        w_best_id   = '0;
        w_best_prio = '0;
        w_best_vld  = '0;
        for (int t = 0; t < NumTarget; t++) begin
            for (int k = 0; k < NumSrc; k++) begin
                if (w_ip[k] && ie_i[t*NumSrc + k] &&
                    (prio_i[k*PrioW +: PrioW] > threshold_i[t*PrioW +: PrioW]) &&
                    (prio_i[k*PrioW +: PrioW] > w_best_prio[t*PrioW +: PrioW])) begin
                    w_best_prio[t*PrioW +: PrioW] = prio_i[k*PrioW +: PrioW];
                    w_best_id[t*SrcW +: SrcW]     = SrcW'(k);
                    w_best_vld[t]                 = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_irq    <= '0;
            r_irq_id <= '0;
        end else begin
            r_irq    <= w_best_vld;
            r_irq_id <= w_best_id;
        end
    end

    assign irq_o    = r_irq;
    assign irq_id_o = r_irq_id;

    // Source 0 has no gateway; its per-source signals terminate here.
    assign w_unused = w_trig[0] ^ w_claim_src[0] ^ w_complete_src[0];

endmodule
